// File: rtl/trim_rx_pkg.sv
// Shared definitions for the BGR trim link: word length, receiver FSM states
// and the MSB-first shift helper used by both ends of the link.
package trim_rx_pkg;

    localparam int unsigned TRIM_W = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } trim_state_e;

    // MSB-first: the newest bit always enters at the LSB end.
    function automatic logic [TRIM_W-1:0] shift_in(input logic [TRIM_W-1:0] word,
                                                   input logic              bit_in);
        return {word[TRIM_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/trim_rx_if.sv
// Trim link bundle: serial strobe/data from the generator side and the
// parallel trim word plus status returned by the receiver.
interface trim_rx_if #(
    parameter int unsigned WIDTH = trim_rx_pkg::TRIM_W
);
    logic             ENCLK;
    logic             DIN;
    logic [WIDTH-1:0] TRIMCODE;
    logic             VALID;
    logic             BUSY;
    logic             ERR;

    modport master (
        output ENCLK, DIN,
        input  TRIMCODE, VALID, BUSY, ERR
    );

    modport slave (
        input  ENCLK, DIN,
        output TRIMCODE, VALID, BUSY, ERR
    );
endinterface

// File: rtl/trim_rx_sync.sv
// Two-flop synchronizer for the asynchronous ENCLK/DIN pair, plus rising-edge
// detect on ENCLK. DIN is delayed by the same two stages to stay bit-aligned.
module trim_sync (
    input  logic clk,
    input  logic rst,
    input  logic enclk,
    input  logic din,
    output logic rise,
    output logic d2
);
    logic e1, e2, e3;
    logic d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            e1 <= 1'b0;
            e2 <= 1'b0;
            e3 <= 1'b0;
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            e1 <= enclk;
            e2 <= e1;
            e3 <= e2;
            d1 <= din;
            d2 <= d1;
        end
    end

    assign rise = e2 & ~e3;

endmodule

// File: rtl/trim_rx.sv
// BGR trim link receiver: oversamples ENCLK/DIN on CLK50, assembles an
// MSB-first word and presents it as TRIMCODE with VALID/BUSY/ERR status.
module trim_rx
    import trim_rx_pkg::*;
#(
    parameter int unsigned      WIDTH    = TRIM_W,
    parameter int unsigned      TIMEOUT  = 64,
    parameter logic [WIDTH-1:0] TRIM_RST = 12'h800
) (
    input  logic     CLK50,
    input  logic     RST,
    trim_rx_if.slave link
);
    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    logic rise, d2;

    trim_state_e      state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n, shifted;
    logic [WIDTH-1:0] trimcode, trimcode_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic [TW-1:0]    tocnt, tocnt_n;
    logic             valid, valid_n;
    logic             busy, busy_n;
    logic             err, err_n;

    trim_sync u_sync (
        .clk   (CLK50),
        .rst   (RST),
        .enclk (link.ENCLK),
        .din   (link.DIN),
        .rise  (rise),
        .d2    (d2)
    );

    always_ff @(posedge CLK50) begin
        if (RST) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            trimcode <= TRIM_RST;
            bitcnt   <= '0;
            tocnt    <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            trimcode <= trimcode_n;
            bitcnt   <= bitcnt_n;
            tocnt    <= tocnt_n;
            valid    <= valid_n;
            busy     <= busy_n;
            err      <= err_n;
        end
    end

    assign shifted = shift_in(shreg, d2);

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        trimcode_n = trimcode;
        bitcnt_n   = bitcnt;
        tocnt_n    = tocnt;
        valid_n    = 1'b0;
        err_n      = 1'b0;

        if (rise) begin
            shreg_n = shifted;
            tocnt_n = '0;
        end

        unique case (state)
            ST_IDLE: begin
                tocnt_n = '0;
                if (rise) begin
                    state_n  = ST_SHIFT;
                    bitcnt_n = BW'(1);
                end
            end
            ST_SHIFT: begin
                if (rise) begin
                    // Commit straight from the shifted value so VALID lands on the same edge as the last bit.
                    if (bitcnt == LAST_BIT) begin
                        state_n    = ST_IDLE;
                        bitcnt_n   = '0;
                        trimcode_n = shifted;
                        valid_n    = 1'b1;
                    end else begin
                        bitcnt_n = bitcnt + BW'(1);
                    end
                end else begin
                    if (tocnt != '1) begin
                        tocnt_n = tocnt + TW'(1);
                    end
                    if (tocnt == TO_LAST) begin
                        state_n  = ST_IDLE;
                        bitcnt_n = '0;
                        err_n    = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n == ST_SHIFT);
    end

    assign link.TRIMCODE = trimcode;
    assign link.VALID    = valid;
    assign link.BUSY     = busy;
    assign link.ERR      = err;

endmodule
